// File: rtl/nonce_search_controller_if.sv
// Host/SHA-side signal bundle for nonce_search_controller.
// The controller uses the slave modport; the host/hash side uses master.
interface nonce_search_controller_if #(
  parameter int NONCE_W = 32
);
  logic               iStart;
  logic               iAbort;
  logic [NONCE_W-1:0] iBaseNonce;
  logic [NONCE_W-1:0] iLastNonce;
  logic               iShaReady;
  logic               iHit;

  logic               oShaStart;
  logic [NONCE_W-1:0] oShaNonce;
  logic               oBusy;
  logic               oDone;
  logic               oFound;
  logic [NONCE_W-1:0] oNonce;
  logic [NONCE_W:0]   oAttempts;
  logic               oError;

  modport master (
    output iStart, iAbort, iBaseNonce, iLastNonce, iShaReady, iHit,
    input  oShaStart, oShaNonce, oBusy, oDone, oFound, oNonce, oAttempts, oError
  );

  modport slave (
    input  iStart, iAbort, iBaseNonce, iLastNonce, iShaReady, iHit,
    output oShaStart, oShaNonce, oBusy, oDone, oFound, oNonce, oAttempts, oError
  );
endinterface

// File: rtl/nonce_search_controller.sv
// Nonce search sequencer: one SHA-1 start per candidate, stops on hit or range end.
// Optional WAIT watchdog compiled in with NONCE_SEARCH_WATCHDOG_EN.
module nonce_search_controller #(
  parameter int NONCE_W = 32,
  parameter int TIMEOUT = 1024
) (
  input logic                      iClk,
  input logic                      iRst,
  nonce_search_controller_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [NONCE_W-1:0] cur_q, cur_d;
  logic [NONCE_W-1:0] last_q, last_d;
  logic [NONCE_W-1:0] sha_nonce_q, sha_nonce_d;
  logic [NONCE_W-1:0] nonce_q, nonce_d;
  logic [NONCE_W:0]   attempts_q, attempts_d;
  logic               sha_start_q, sha_start_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               found_q, found_d;

`ifdef NONCE_SEARCH_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            error_q, error_d;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
`endif

  // Outputs are all flops whose next value is chosen alongside the next
  // state, so each output reflects the state it belongs to with no decode lag.
  always_comb begin
    // NOTE: every _d gets a default before the case so no path leaves it
    // unassigned; an unassigned path in always_comb would infer a latch.
    state_d     = state_q;
    cur_d       = cur_q;
    last_d      = last_q;
    sha_nonce_d = sha_nonce_q;
    nonce_d     = nonce_q;
    attempts_d  = attempts_q;
    found_d     = found_q;
    sha_start_d = 1'b0;
    done_d      = 1'b0;
`ifdef NONCE_SEARCH_WATCHDOG_EN
    wd_d        = wd_q;
    error_d     = error_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.iStart) begin
          last_d      = bus.iLastNonce;
          cur_d       = bus.iBaseNonce;
          sha_nonce_d = bus.iBaseNonce;
          sha_start_d = 1'b1;
          attempts_d  = '0;
          found_d     = 1'b0;
          nonce_d     = '0;
`ifdef NONCE_SEARCH_WATCHDOG_EN
          error_d     = 1'b0;
`endif
          state_d     = S_ISSUE;
        end
      end

      S_ISSUE: begin
`ifdef NONCE_SEARCH_WATCHDOG_EN
        wd_d    = '0;
`endif
        state_d = S_WAIT;
      end

      S_WAIT: begin
        if (bus.iShaReady) begin
          state_d = S_CHECK;
`ifdef NONCE_SEARCH_WATCHDOG_EN
        end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
          // Last allowed WAIT cycle without a digest: give up on this search.
          error_d = 1'b1;
          found_d = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          wd_d    = wd_q + 1'b1;
`endif
        end
      end

      S_CHECK: begin
        attempts_d = attempts_q + 1'b1;
        if (bus.iHit) begin
          nonce_d = cur_q;
          found_d = 1'b1;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else if (cur_q == last_q) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          // Natural NONCE_W-bit wrap gives the base > last wrap-around search.
          cur_d       = cur_q + 1'b1;
          sha_nonce_d = cur_q + 1'b1;
          sha_start_d = 1'b1;
          state_d     = S_ISSUE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort overrides whatever the state decided, including a same-cycle
    // ready or hit, and leaves the result registers untouched.
    if (bus.iAbort && (state_q != S_IDLE)) begin
      state_d     = S_IDLE;
      cur_d       = cur_q;
      sha_nonce_d = sha_nonce_q;
      nonce_d     = nonce_q;
      attempts_d  = attempts_q;
      found_d     = found_q;
      sha_start_d = 1'b0;
      done_d      = 1'b0;
`ifdef NONCE_SEARCH_WATCHDOG_EN
      error_d     = error_q;
`endif
    end

    busy_d = (state_d != S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of the others regardless of statement order.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q     <= S_IDLE;
      cur_q       <= '0;
      last_q      <= '0;
      sha_nonce_q <= '0;
      nonce_q     <= '0;
      attempts_q  <= '0;
      sha_start_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      found_q     <= 1'b0;
`ifdef NONCE_SEARCH_WATCHDOG_EN
      wd_q        <= '0;
      error_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      last_q      <= last_d;
      sha_nonce_q <= sha_nonce_d;
      nonce_q     <= nonce_d;
      attempts_q  <= attempts_d;
      sha_start_q <= sha_start_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      found_q     <= found_d;
`ifdef NONCE_SEARCH_WATCHDOG_EN
      wd_q        <= wd_d;
      error_q     <= error_d;
`endif
    end
  end

  assign bus.oShaStart = sha_start_q;
  assign bus.oShaNonce = sha_nonce_q;
  assign bus.oBusy     = busy_q;
  assign bus.oDone     = done_q;
  assign bus.oFound    = found_q;
  assign bus.oNonce    = nonce_q;
  assign bus.oAttempts = attempts_q;
`ifdef NONCE_SEARCH_WATCHDOG_EN
  assign bus.oError    = error_q;
`else
  assign bus.oError    = 1'b0;
`endif

endmodule

// File: tb/tb_nonce_search_controller.sv
// Directed bench for nonce_search_controller: table of search ranges plus
// hand sequences for abort, busy-start, no-ready/watchdog, reset and full range.
module tb_nonce_search_controller;

  localparam int NW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  nonce_search_controller_if #(.NONCE_W(NW)) bus ();
  nonce_search_controller_if #(.NONCE_W(4))  sbus ();

  nonce_search_controller #(.NONCE_W(NW), .TIMEOUT(8)) u_dut (
    .iClk (clk),
    .iRst (rst),
    .bus  (bus)
  );

  nonce_search_controller #(.NONCE_W(4), .TIMEOUT(8)) u_small (
    .iClk (clk),
    .iRst (rst),
    .bus  (sbus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] base;
    logic [31:0] last;
    logic        hit_en;
    logic [31:0] hit_nonce;
    logic        exp_found;
    logic [31:0] exp_nonce;
    logic [32:0] exp_attempts;
    logic [31:0] exp_last_sha;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are read 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_search(input vec_t v, input string tag);
    logic [31:0] exp_cur;
    bit          finished;
    finished = 1'b0;
    exp_cur  = v.base;
    bus.iBaseNonce = v.base;
    bus.iLastNonce = v.last;
    bus.iStart     = 1'b1;
    tick();
    bus.iStart = 1'b0;
    check({tag, " busy"}, 64'(bus.oBusy), 64'd1);
    for (int i = 0; i < 8 && !finished; i++) begin
      check({tag, " sha_start"}, 64'(bus.oShaStart), 64'd1);
      check({tag, " sha_nonce"}, 64'(bus.oShaNonce), 64'(exp_cur));
      tick();
      tick();
      bus.iShaReady = 1'b1;
      tick();
      bus.iShaReady = 1'b0;
      bus.iHit = v.hit_en && (exp_cur == v.hit_nonce);
      tick();
      bus.iHit = 1'b0;
      if (bus.oDone) finished = 1'b1;
      else exp_cur = exp_cur + 32'd1;
    end
    check({tag, " done"},      64'(finished),      64'd1);
    check({tag, " found"},     64'(bus.oFound),    64'(v.exp_found));
    check({tag, " nonce"},     64'(bus.oNonce),    64'(v.exp_nonce));
    check({tag, " attempts"},  64'(bus.oAttempts), 64'(v.exp_attempts));
    check({tag, " last_sha"},  64'(bus.oShaNonce), 64'(v.exp_last_sha));
    check({tag, " error"},     64'(bus.oError),    64'd0);
    tick();
    check({tag, " idle busy"}, 64'(bus.oBusy),     64'd0);
    check({tag, " one done"},  64'(bus.oDone),     64'd0);
    check({tag, " hold found"},64'(bus.oFound),    64'(v.exp_found));
  endtask

  initial begin
    bit done_seen;
    bit finished;
    int pulses;
    vec_t v;

    vecs[0] = '{32'h10, 32'h14, 1'b1, 32'h12, 1'b1, 32'h12, 33'd3, 32'h12};
    vecs[1] = '{32'h5,  32'h7,  1'b0, 32'h0,  1'b0, 32'h0,  33'd3, 32'h7};
    vecs[2] = '{32'hFFFF_FFFE, 32'h1, 1'b0, 32'h0, 1'b0, 32'h0, 33'd4, 32'h1};
    vecs[3] = '{32'h42, 32'h42, 1'b0, 32'h0,  1'b0, 32'h0,  33'd1, 32'h42};
    vecs[4] = '{32'h100, 32'h100, 1'b1, 32'h100, 1'b1, 32'h100, 33'd1, 32'h100};
    vecs[5] = '{32'hFFFF_FFFF, 32'h0, 1'b1, 32'h0, 1'b1, 32'h0, 33'd2, 32'h0};

    bus.iStart = 1'b0; bus.iAbort = 1'b0; bus.iBaseNonce = '0; bus.iLastNonce = '0;
    bus.iShaReady = 1'b0; bus.iHit = 1'b0;
    sbus.iStart = 1'b0; sbus.iAbort = 1'b0; sbus.iBaseNonce = '0; sbus.iLastNonce = '0;
    sbus.iShaReady = 1'b0; sbus.iHit = 1'b0;

    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst sha_start", 64'(bus.oShaStart), 64'd0);
    check("rst sha_nonce", 64'(bus.oShaNonce), 64'd0);
    check("rst busy",      64'(bus.oBusy),     64'd0);
    check("rst done",      64'(bus.oDone),     64'd0);
    check("rst found",     64'(bus.oFound),    64'd0);
    check("rst nonce",     64'(bus.oNonce),    64'd0);
    check("rst attempts",  64'(bus.oAttempts), 64'd0);
    check("rst error",     64'(bus.oError),    64'd0);

    for (int i = 0; i < 6; i++) begin
      run_search(vecs[i], $sformatf("vec%0d", i));
    end

    // Abort together with ready/hit on the 2nd nonce; start while busy ignored.
    bus.iBaseNonce = 32'h20; bus.iLastNonce = 32'h30; bus.iStart = 1'b1;
    tick();
    bus.iStart = 1'b0;
    tick();
    bus.iShaReady = 1'b1;
    tick();
    bus.iShaReady = 1'b0;
    tick();
    check("abort 2nd start", 64'(bus.oShaStart), 64'd1);
    check("abort 2nd nonce", 64'(bus.oShaNonce), 64'h21);
    tick();
    bus.iBaseNonce = 32'h99; bus.iStart = 1'b1;
    tick();
    bus.iStart = 1'b0;
    check("busy start busy",  64'(bus.oBusy),     64'd1);
    check("busy start pulse", 64'(bus.oShaStart), 64'd0);
    check("busy start nonce", 64'(bus.oShaNonce), 64'h21);
    bus.iShaReady = 1'b1; bus.iHit = 1'b1; bus.iAbort = 1'b1;
    tick();
    bus.iShaReady = 1'b0; bus.iHit = 1'b0; bus.iAbort = 1'b0;
    check("abort busy",     64'(bus.oBusy),     64'd0);
    check("abort done",     64'(bus.oDone),     64'd0);
    check("abort found",    64'(bus.oFound),    64'd0);
    check("abort attempts", 64'(bus.oAttempts), 64'd1);
    done_seen = 1'b0;
    repeat (3) begin
      tick();
      if (bus.oDone || bus.oShaStart) done_seen = 1'b1;
    end
    check("abort quiet", 64'(done_seen), 64'd0);
    v = '{32'h30, 32'h31, 1'b1, 32'h31, 1'b1, 32'h31, 33'd2, 32'h31};
    run_search(v, "after abort");

    // Start and abort together in IDLE: start wins; abort in ISSUE still pulses.
    bus.iBaseNonce = 32'h77; bus.iLastNonce = 32'h78;
    bus.iStart = 1'b1; bus.iAbort = 1'b1;
    tick();
    bus.iStart = 1'b0;
    check("start+abort busy",  64'(bus.oBusy),     64'd1);
    check("start+abort pulse", 64'(bus.oShaStart), 64'd1);
    tick();
    bus.iAbort = 1'b0;
    check("issue abort busy",  64'(bus.oBusy),     64'd0);
    check("issue abort pulse", 64'(bus.oShaStart), 64'd0);

    // No digest ever arrives.
    bus.iBaseNonce = 32'h7; bus.iLastNonce = 32'h7; bus.iStart = 1'b1;
    tick();
    bus.iStart = 1'b0;
    tick();
    done_seen = 1'b0;
    for (int j = 1; j <= 7; j++) begin
      tick();
      if (bus.oDone) done_seen = 1'b1;
    end
    check("wd early done", 64'(done_seen), 64'd0);
    tick();
`ifdef NONCE_SEARCH_WATCHDOG_EN
    check("wd done",  64'(bus.oDone),  64'd1);
    check("wd error", 64'(bus.oError), 64'd1);
    check("wd found", 64'(bus.oFound), 64'd0);
`else
    check("nowd done", 64'(bus.oDone), 64'd0);
    check("nowd busy", 64'(bus.oBusy), 64'd1);
`endif
    tick();

    // Reset while in WAIT.
    if (!bus.oBusy) begin
      bus.iBaseNonce = 32'h55; bus.iLastNonce = 32'h60; bus.iStart = 1'b1;
      tick();
      bus.iStart = 1'b0;
      tick();
    end
    check("pre-rst sha_nonce", 64'(bus.oShaNonce == '0), 64'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("wait rst busy",     64'(bus.oBusy),     64'd0);
    check("wait rst sha_nonce",64'(bus.oShaNonce), 64'd0);
    check("wait rst start",    64'(bus.oShaStart), 64'd0);
    check("wait rst done",     64'(bus.oDone),     64'd0);
    check("wait rst error",    64'(bus.oError),    64'd0);
    check("wait rst attempts", 64'(bus.oAttempts), 64'd0);
    run_search(vecs[1], "after rst");

    // Full 4-bit range on the small instance: 16 attempts, no overflow.
    sbus.iShaReady = 1'b1; sbus.iHit = 1'b0;
    sbus.iBaseNonce = 4'h5; sbus.iLastNonce = 4'h4; sbus.iStart = 1'b1;
    tick();
    sbus.iStart = 1'b0;
    pulses = 0;
    finished = 1'b0;
    for (int c = 0; c < 100 && !finished; c++) begin
      if (sbus.oShaStart) pulses++;
      if (sbus.oDone) finished = 1'b1;
      else tick();
    end
    sbus.iShaReady = 1'b0;
    check("full done",     64'(finished),       64'd1);
    check("full pulses",   64'(pulses),         64'd16);
    check("full attempts", 64'(sbus.oAttempts), 64'd16);
    check("full found",    64'(sbus.oFound),    64'd0);
    check("full last",     64'(sbus.oShaNonce), 64'h4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nonce_search_controller.md
# nonce_search_controller

Drives the SHA-1 core and collision checker through a nonce search: issues one hash per candidate nonce, waits for the digest-ready pulse, samples the registered collision flag, and either stops on a hit or advances to the next nonce until the programmed range is exhausted. It sits on the request side of the hash/checker path. It turns a host-level "search range" command into per-hash start pulses and returns the winning nonce.

## Interface
- NONCE_W, 32, width of nonce, range bounds and found-nonce output
- TIMEOUT, 1024, max cycles in WAIT before watchdog fires (used only with watchdog compiled in)

- iClk  in  1  clock; all state updates on rising edge
- iRst  in  1  reset, synchronous, active-high
- iStart  in  1  one-cycle request to begin a search; ignored unless IDLE
- iAbort  in  1  cancel search in progress
- iBaseNonce  in  NONCE_W  first nonce to try; latched on accepted iStart
- iLastNonce  in  NONCE_W  last nonce to try, inclusive; latched on accepted iStart
- iShaReady  in  1  digest-ready pulse from SHA-1 core
- iHit  in  1  registered collision flag from checker; valid the cycle after iShaReady
- oShaStart  out  1  one-cycle pulse starting a hash
- oShaNonce  out  NONCE_W  nonce under hash; stable from oShaStart until CHECK completes
- oBusy  out  1  high in any state except IDLE
- oDone  out  1  one-cycle pulse at search end (hit, exhaustion or timeout)
- oFound  out  1  last search ended on a hit; holds until next accepted iStart
- oNonce  out  NONCE_W  winning nonce; valid while oFound=1
- oAttempts  out  NONCE_W+1  hashes checked in current/last search
- oError  out  1  last search ended by watchdog; holds until next accepted iStart

## Operation
- States: IDLE, ISSUE, WAIT, CHECK, DONE.
- IDLE: iStart=1 latches base/last, sets cur=base, clears oAttempts/oFound/oError/oNonce, goes to ISSUE.
- ISSUE: oShaStart=1 for exactly this cycle, oShaNonce=cur; goes to WAIT.
- WAIT: iShaReady=1 goes to CHECK. iShaReady in any other state is ignored.
- CHECK: samples iHit; oAttempts+1.
  - If iHit=1: oNonce=cur, oFound=1, go to DONE.
  - Else if cur==last: go to DONE with oFound=0.
  - Else: cur=cur+1 mod 2^NONCE_W, go to ISSUE.
- DONE: oDone=1 for one cycle, then IDLE.
- Wrap-around: if base>last, the search runs through 2^NONCE_W−1, wraps to 0 and ends at last. base==last hashes exactly one nonce. Full range (last = base−1) gives oAttempts = 2^NONCE_W with no overflow.
- iAbort in any non-IDLE state: next state IDLE, no oDone pulse, oFound/oError stay 0.
  - Abort beats iShaReady/iHit in the same cycle.
  - Abort in ISSUE still lets that cycle's oShaStart pulse out.
- iStart while busy is ignored; iStart and iAbort together in IDLE: start wins.
- Reset values: oShaStart=0, oShaNonce=0, oBusy=0, oDone=0, oFound=0, oNonce=0, oAttempts=0, oError=0, state=IDLE. Reset mid-search discards everything.

## Timing
- All outputs registered.
- iStart at cycle 0 gives oBusy=1 and oShaStart=1 in cycle 1, with oShaNonce=base.
- iShaReady at cycle k gives CHECK at k+1 (iHit sampled at k+1).
- At k+2: on continue, oShaStart with oShaNonce=cur+1; on end, oDone=1.
- Per-nonce overhead beyond SHA latency: 3 cycles (ISSUE, CHECK, ready-to-CHECK edge).
- oFound, oNonce and oError update in the oDone cycle and hold afterwards. oBusy drops the cycle after oDone.

## Configuration
- NONCE_SEARCH_WATCHDOG_EN defined:
  - WAIT counts cycles; reaching TIMEOUT without iShaReady goes to DONE with oError=1, oFound=0.
  - Counter clears on each entry to WAIT.
- Undefined: no counter, WAIT holds indefinitely, oError tied 0.

## Test plan
- Base=0x10, last=0x14, iHit=1 only for nonce 0x12 → oShaStart pulses for 0x10, 0x11, 0x12; oDone, oFound=1, oNonce=0x12, oAttempts=3.
- Base=5, last=7, iHit always 0 → three hashes; oDone with oFound=0, oAttempts=3, oShaNonce last =7.
- Base=0xFFFFFFFE, last=0x1, no hits → nonces FFFFFFFE, FFFFFFFF, 0, 1 in order; oAttempts=4.
- iAbort on the same cycle as iShaReady during the 2nd nonce → IDLE next cycle; no oDone; iStart during search ignored; new iStart then works cleanly.
- Watchdog build, TIMEOUT=8, iShaReady never asserted → oDone exactly 8 cycles after entering WAIT, oError=1; non-watchdog build stays oBusy=1.
- iRst asserted in WAIT → next cycle all outputs at reset values and state IDLE.
